// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-network readout blocks.
package snn_pkg;

  localparam int unsigned DefaultNumClasses = 10;
  localparam int unsigned DefaultDataWidth  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } readout_state_t;

endpackage

// File: rtl/argmax_compare_element.sv
// Combinational best-vs-candidate compare; strict greater-than so ties keep the lower index.
module argmax_compare_element #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] best_val_i,
  input  logic [IDX_WIDTH-1:0]  best_idx_i,
  input  logic [DATA_WIDTH-1:0] cand_val_i,
  input  logic [IDX_WIDTH-1:0]  cand_idx_i,
  output logic [DATA_WIDTH-1:0] new_val_o,
  output logic [IDX_WIDTH-1:0]  new_idx_o,
  output logic                  replace_o
);

  always_comb begin
    replace_o = cand_val_i > best_val_i;
    new_val_o = replace_o ? cand_val_i : best_val_i;
    new_idx_o = replace_o ? cand_idx_i : best_idx_i;
  end

endmodule

// File: rtl/spike_argmax_readout.sv
// Sequential argmax over per-class spike counts, one class per cycle.
// Define READOUT_MARGIN_EN to track the runner-up and expose the margin port.
module spike_argmax_readout
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DefaultNumClasses,
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] counts,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_WIDTH-1:0]              winner_idx,
  output logic [DATA_WIDTH-1:0]             winner_count,
`ifdef READOUT_MARGIN_EN
  output logic [DATA_WIDTH-1:0]             margin,
`endif
  output logic                              no_spike
);

  // Scan counter must reach NUM_CLASSES to spend one extra cycle publishing the result.
  localparam int unsigned CntWidth = $clog2(NUM_CLASSES + 1);

  readout_state_t        state_q;
  logic [DATA_WIDTH-1:0] snap_q [NUM_CLASSES];
  logic [CntWidth-1:0]   scan_q;
  logic [DATA_WIDTH-1:0] best_val_q;
  logic [IDX_WIDTH-1:0]  best_idx_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [IDX_WIDTH-1:0]  winner_idx_q;
  logic [DATA_WIDTH-1:0] winner_count_q;
  logic                  no_spike_q;
`ifdef READOUT_MARGIN_EN
  logic [DATA_WIDTH-1:0] second_q;
  logic [DATA_WIDTH-1:0] margin_q;
`endif

  logic [IDX_WIDTH-1:0]  cand_idx;
  logic [DATA_WIDTH-1:0] cand_val;
  logic [DATA_WIDTH-1:0] new_val;
  logic [IDX_WIDTH-1:0]  new_idx;
  logic                  replace;
  logic                  scan_end;

  assign cand_idx = scan_q[IDX_WIDTH-1:0];
  assign cand_val = snap_q[cand_idx];
  assign scan_end = scan_q == CntWidth'(NUM_CLASSES);

  argmax_compare_element #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_compare (
    .best_val_i (best_val_q),
    .best_idx_i (best_idx_q),
    .cand_val_i (cand_val),
    .cand_idx_i (cand_idx),
    .new_val_o  (new_val),
    .new_idx_o  (new_idx),
    .replace_o  (replace)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      scan_q         <= '0;
      best_val_q     <= '0;
      best_idx_q     <= '0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      no_spike_q     <= 1'b0;
`ifdef READOUT_MARGIN_EN
      second_q       <= '0;
      margin_q       <= '0;
`endif
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              snap_q[k] <= counts[k*DATA_WIDTH +: DATA_WIDTH];
            end
            best_val_q <= counts[DATA_WIDTH-1:0];
            best_idx_q <= '0;
            scan_q     <= CntWidth'(1);
            busy_q     <= 1'b1;
            state_q    <= StScan;
`ifdef READOUT_MARGIN_EN
            second_q   <= '0;
`endif
          end
        end
        StScan: begin
          if (scan_end) begin
            winner_idx_q   <= best_idx_q;
            winner_count_q <= best_val_q;
            no_spike_q     <= best_val_q == '0;
            out_valid_q    <= 1'b1;
            state_q        <= StDone;
`ifdef READOUT_MARGIN_EN
            margin_q       <= best_val_q - second_q;
`endif
          end else begin
            best_val_q <= new_val;
            best_idx_q <= new_idx;
            scan_q     <= scan_q + CntWidth'(1);
`ifdef READOUT_MARGIN_EN
            // Old best becomes runner-up on replacement; a tie with best lands here too.
            if (replace) begin
              second_q <= best_val_q;
            end else if (cand_val > second_q) begin
              second_q <= cand_val;
            end
`endif
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign winner_idx   = winner_idx_q;
  assign winner_count = winner_count_q;
  assign no_spike     = no_spike_q;
`ifdef READOUT_MARGIN_EN
  assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_spike_argmax_readout.sv
// Directed bench for spike_argmax_readout with hand-computed expected results.
module tb_spike_argmax_readout;

  localparam int unsigned N  = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [N*DW-1:0]   counts;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     winner_idx;
  logic [DW-1:0]     winner_count;
  logic              no_spike;
`ifdef READOUT_MARGIN_EN
  logic [DW-1:0]     margin;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_argmax_readout #(
    .NUM_CLASSES (N),
    .DATA_WIDTH  (DW)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .counts       (counts),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .winner_idx   (winner_idx),
    .winner_count (winner_count),
`ifdef READOUT_MARGIN_EN
    .margin       (margin),
`endif
    .no_spike     (no_spike)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input int unsigned v[N]);
    logic [N*DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Edges counted from the accepting edge until out_valid is seen; bounded at 40.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;
  int extra;
  logic [N*DW-1:0] vec_a;
  logic [N*DW-1:0] vec_b;

  initial begin
    vec_a     = pack('{3, 7, 2, 9, 9, 0, 1, 4, 5, 6});
    vec_b     = pack('{1, 2, 3, 4, 5, 6, 7, 8, 9, 40});
    rstn      = 1'b0;
    start     = 1'b0;
    counts    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_idx", 32'(winner_idx), 0);
    check_eq("rst_count", 32'(winner_count), 0);
    check_eq("rst_nospike", 32'(no_spike), 0);
`ifdef READOUT_MARGIN_EN
    check_eq("rst_margin", 32'(margin), 0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Tie between classes 3 and 4 resolves to 3.
    counts    = vec_a;
    out_ready = 1'b1;
    pulse_start();
    check_eq("t1_busy_scan", 32'(busy), 1);
    wait_valid(lat);
    check_eq("t1_latency", 32'(lat), 10);
    check_eq("t1_idx", 32'(winner_idx), 3);
    check_eq("t1_count", 32'(winner_count), 9);
    check_eq("t1_nospike", 32'(no_spike), 0);
`ifdef READOUT_MARGIN_EN
    check_eq("t1_margin", 32'(margin), 0);
`endif
    @(posedge clk);
    #1;
    check_eq("t1_valid_done", 32'(out_valid), 0);
    check_eq("t1_busy_done", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t1_idle_hold_idx", 32'(winner_idx), 3);

    counts = '0;
    pulse_start();
    wait_valid(lat);
    check_eq("t2_latency", 32'(lat), 10);
    check_eq("t2_idx", 32'(winner_idx), 0);
    check_eq("t2_count", 32'(winner_count), 0);
    check_eq("t2_nospike", 32'(no_spike), 1);
    @(posedge clk);
    #1;

    // Back-pressure: result held while out_ready is low.
    counts    = vec_b;
    out_ready = 1'b0;
    pulse_start();
    wait_valid(lat);
    check_eq("t3_latency", 32'(lat), 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("t3_hold_valid", 32'(out_valid), 1);
      check_eq("t3_hold_idx", 32'(winner_idx), 9);
      check_eq("t3_hold_count", 32'(winner_count), 40);
`ifdef READOUT_MARGIN_EN
      check_eq("t3_hold_margin", 32'(margin), 31);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t3_valid_done", 32'(out_valid), 0);
    check_eq("t3_busy_done", 32'(busy), 0);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check_eq("t3_single_hs", 32'(extra), 0);

    // Snapshot isolation; start held high through scan and through the handshake edge.
    counts = pack('{5, 1, 8, 2, 8, 3, 0, 7, 6, 4});
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 counts = '1;
    wait_valid(lat);
    check_eq("t4_latency", 32'(lat), 10);
    check_eq("t4_idx", 32'(winner_idx), 2);
    check_eq("t4_count", 32'(winner_count), 8);
`ifdef READOUT_MARGIN_EN
    check_eq("t4_margin", 32'(margin), 0);
`endif
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("t4_busy_after", 32'(busy), 0);
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) extra++;
    end
    check_eq("t4_one_result", 32'(extra), 0);

    // Reset during the scan aborts the readout.
    counts = vec_a;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 0);
    check_eq("t5_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    check_eq("t5_no_result", 32'(extra), 0);
    check_eq("t5_idx_cleared", 32'(winner_idx), 0);
    counts = vec_b;
    pulse_start();
    wait_valid(lat);
    check_eq("t5_latency", 32'(lat), 10);
    check_eq("t5_idx", 32'(winner_idx), 9);
    check_eq("t5_count", 32'(winner_count), 40);
    @(posedge clk);
    #1;
    check_eq("t5_busy_done", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_argmax_readout.md
SPIKE_ARGMAX_READOUT -- requirements
Module: spike_argmax_readout

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class accumulators scanned; legal range 2..256.
REQ-002 Parameter DATA_WIDTH, default 16, width of each spike count.
REQ-003 Local parameter IDX_WIDTH = $clog2(NUM_CLASSES), width of the class index.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one readout of the current counts; sampled only in IDLE.
REQ-007 counts  input  NUM_CLASSES*DATA_WIDTH  packed per-class spike counts; class k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 busy  output  1  high in SCAN and DONE.
REQ-009 out_valid  output  1  result valid; high only in DONE.
REQ-010 out_ready  input  1  consumer accepts result when high together with out_valid.
REQ-011 winner_idx  output  IDX_WIDTH  class index with the highest count.
REQ-012 winner_count  output  DATA_WIDTH  count of the winning class.
REQ-013 no_spike  output  1  high with out_valid when winner_count == 0.
REQ-014 margin  output  DATA_WIDTH  winner_count minus runner-up count; present only with READOUT_MARGIN_EN.

Function
REQ-015 FSM states: IDLE, SCAN, DONE.
REQ-016 IDLE & start: snapshot all counts into an internal register, load best = class 0, scan index = 1, go to SCAN.
REQ-017 SCAN: compare one snapshot class per cycle, indices 1..NUM_CLASSES-1 ascending; after index NUM_CLASSES-1, go to DONE.
REQ-018 Replacement rule: candidate replaces best only if strictly greater; ties resolve to the lowest index.
REQ-019 Latency: out_valid rises exactly NUM_CLASSES cycles after the clock edge that accepts start.
REQ-020 DONE: out_valid, winner_idx, winner_count, no_spike, margin held stable until out_valid & out_ready; then go to IDLE on that edge.
REQ-021 Changes on counts after the snapshot do not affect the result.
REQ-022 start while busy is ignored, not queued; start in the same cycle as the DONE handshake is ignored.
REQ-023 Result outputs keep the last result while in IDLE; only out_valid qualifies them.
REQ-024 All comparisons are unsigned, full DATA_WIDTH; no saturation or wrap handling needed (inputs are final counts).
REQ-025 All-zero counts: winner_idx = 0, winner_count = 0, no_spike = 1.

Reset
REQ-026 rstn low: state = IDLE, busy = 0, out_valid = 0, winner_idx = 0, winner_count = 0, no_spike = 0, margin = 0, snapshot cleared.
REQ-027 Reset asserted mid-SCAN or in DONE aborts the readout; no result is delivered after release.

Configuration
REQ-028 Macro READOUT_MARGIN_EN defined: runner-up is tracked during the scan (updated when a candidate is greater than the runner-up but does not replace best, or takes the old best on replacement), and the margin port is present.
REQ-029 Macro READOUT_MARGIN_EN defined: tie between best and runner-up gives margin = 0.
REQ-030 Macro READOUT_MARGIN_EN undefined: no runner-up logic, no margin port; all other behaviour identical.

Structure
REQ-031 Shared package snn_pkg holds the FSM state enum typedef (readout_state_t) and default DATA_WIDTH/NUM_CLASSES constants.
REQ-032 One sub-module argmax_compare_element: combinational best/candidate compare returning new best value, index and replace flag; instantiated once.

Verification
REQ-033 NUM_CLASSES=10, counts {3,7,2,9,9,0,1,4,5,6}, start pulse, out_ready=1 -> out_valid at +10 cycles, winner_idx=3, winner_count=9, margin=0.
REQ-034 All counts 0, start -> winner_idx=0, winner_count=0, no_spike=1 after 10 cycles.
REQ-035 counts {1,2,3,4,5,6,7,8,9,40}, out_ready=0 for 5 cycles after out_valid -> outputs stable, winner_idx=9, margin=31, single handshake, then busy=0.
REQ-036 start accepted, counts changed to all 0xFFFF during SCAN, extra start pulses -> result from snapshot, exactly one result delivered.
REQ-037 rstn asserted at cycle 4 of SCAN -> out_valid never rises, busy=0; next start completes a normal readout.
